logic_gate_pipe: RTL and testbench
==================================

// Module: logic_gate_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single XNOR gate: a WIDTH-bit two-operand logic unit with runtime op select.
//  Every beat also reports an equality/bit-match summary, computed as the popcount of XNOR(a,b).
//  Uses a valid/ready stream on both sides and keeps saturating mismatch and beat counters.
//  Used as a checker/compare stage between datapath blocks and in self-test harnesses.
// PARAMETERS
//  WIDTH  8   operand/result width in bits (>=1)
//  CNT_W  16  width of err_cnt and beat_cnt (>=1)
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 asynchronous, active-high reset
//  in_valid   in   1                 input beat valid
//  in_ready   out  1                 input beat accepted when in_valid&&in_ready
//  in_a       in   WIDTH             operand A
//  in_b       in   WIDTH             operand B
//  in_op      in   3                 op code (see BEHAVIOUR)
//  out_valid  out  1                 result beat valid
//  out_ready  in   1                 downstream accepts when out_valid&&out_ready
//  out_y      out  WIDTH             op(a,b) result
//  out_ones   out  $clog2(WIDTH+1)   number of bit positions where a==b
//  out_eq     out  1                 1 when a==b (out_ones==WIDTH)
//  clr_cnt    in   1                 synchronous clear of both counters
//  err_cnt    out  CNT_W             count of delivered beats with out_eq==0, saturating
//  beat_cnt   out  CNT_W             count of delivered beats, saturating
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
//  - Reset (async assert): both stage valids=0, out_valid=0, out_y=0, out_ones=0, out_eq=0, err_cnt=0, beat_cnt=0.
//    In-flight beats are discarded. in_ready=1 once rst deasserts.
//  - Op codes: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A, 7 BUF A.
//  - out_ones and out_eq always derive from XNOR(a,b), independent of in_op.
//  - Pipeline: 2 register stages.
//    S1 registers op result and XNOR vector. S2 registers out_y, out_ones, out_eq.
//    Latency: accepted input -> out_valid exactly 2 cycles later with no stall. Throughput 1 beat/cycle.
//  - Handshake:
//    S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || S2 loads.
//    in_ready = !s1_valid || S2 loads (combinational; no combinational path from in_valid to in_ready).
//    Max 2 beats in flight. Order preserved. No drop or duplication under any out_ready pattern.
//    out_* are held stable while out_valid && !out_ready.
//  - Counters update only on delivery (out_valid&&out_ready):
//    beat_cnt += 1; err_cnt += 1 if out_eq==0.
//    Both saturate at all-ones and never wrap.
//    clr_cnt has priority over a same-cycle increment: the counter becomes 0, that beat is not counted.
//  - in_valid with in_ready=0: inputs ignored, upstream must hold.
//  - X on in_op while in_valid=0 must not propagate.
// STRUCTURE
//  - Shared package logic_gate_pkg: localparams OP_AND..OP_BUFA (3-bit codes above), OP_W=3.
//  - Sub-module bit_popcount #(WIDTH): combinational popcount, WIDTH -> $clog2(WIDTH+1).
//    Instantiated between S1 and S2.
//  - Remainder (op mux, 2-stage valid/ready pipe, counters) stays in this module.
// TESTING (WIDTH=8, CNT_W=16 unless stated)
//  1 Op table: a=8'hA5, b=8'h0F, ops 0..7 -> out_y = 05,AF,AA,55,FA,50,5A,A5.
//    Every beat: out_ones=4, out_eq=0, out_valid 2 cycles after accept.
//  2 Equality: a=b=8'h3C, op=XNOR -> out_y=8'hFF, out_ones=8, out_eq=1.
//    beat_cnt increments by 1, err_cnt unchanged.
//  3 Backpressure: stream 6 beats, out_ready=0 for 5 cycles.
//    -> in_ready=0 after 2 accepted; out_* stable while stalled; all 6 delivered in order, values match model.
//  4 Saturation: CNT_W=4, 20 delivered mismatch beats -> err_cnt=4'hF, beat_cnt=4'hF.
//    Then clr_cnt=1 on the same cycle as a mismatch delivery -> both counters 0 next cycle.
//  5 Reset mid-op: assert rst with 2 beats in flight and out_ready=0.
//    -> out_valid=0 and counters=0 in the same cycle (async); no stale beat emitted after release.
//  6 Random: 10k beats, random in_valid/out_ready/op, scoreboard vs reference model.
//    -> zero mismatches; err_cnt equals the model count.

Source files
------------

// File: rtl/logic_gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_gate_pkg                                                              |
// | Shared op codes for the logic_gate_pipe two-operand logic unit.             |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
package logic_gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
    localparam logic [OP_W-1:0] OP_BUFA = 3'd7;

endpackage
`default_nettype wire

// File: rtl/bit_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bit_popcount                                                                |
// | Combinational count of set bits in a WIDTH-bit vector.                      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module bit_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           i_vec,
    output logic [$clog2(WIDTH+1)-1:0] o_count
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + c_cnt_w'(i_vec[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_gate_pipe                                                             |
// | Two-stage valid/ready logic unit with XNOR match summary and counters.      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [OP_W-1:0]            in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_y,
    output logic [$clog2(WIDTH+1)-1:0] out_ones,
    output logic                       out_eq,
    input  logic                       clr_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           beat_cnt
);

    localparam int                c_ones_w    = $clog2(WIDTH + 1);
    localparam logic [c_ones_w-1:0] c_all_match = c_ones_w'(WIDTH);

    logic                r_s1_valid;
    logic [WIDTH-1:0]    r_s1_y;
    logic [WIDTH-1:0]    r_s1_xnor;
    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_s2_y;
    logic [c_ones_w-1:0] r_s2_ones;
    logic                r_s2_eq;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic                w_s1_load;
    logic                w_s2_load;
    logic                w_deliver;
    logic [WIDTH-1:0]    w_op_y;
    logic [c_ones_w-1:0] w_ones;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_deliver = r_s2_valid && out_ready;

    always_comb begin
        w_op_y = in_a;
        case (in_op)
            OP_AND:  w_op_y = in_a & in_b;
            OP_OR:   w_op_y = in_a | in_b;
            OP_XOR:  w_op_y = in_a ^ in_b;
            OP_XNOR: w_op_y = ~(in_a ^ in_b);
            OP_NAND: w_op_y = ~(in_a & in_b);
            OP_NOR:  w_op_y = ~(in_a | in_b);
            OP_NOTA: w_op_y = ~in_a;
            OP_BUFA: w_op_y = in_a;
            default: w_op_y = in_a;
        endcase
    end

    // Data registers load only on a real beat, so an undriven in_op while idle never reaches S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_y     <= '0;
            r_s1_xnor  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_y    <= w_op_y;
                r_s1_xnor <= ~(in_a ^ in_b);
            end
        end
    end

    bit_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .i_vec   (r_s1_xnor),
        .o_count (w_ones)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_ones  <= '0;
            r_s2_eq    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y    <= r_s1_y;
                r_s2_ones <= w_ones;
                r_s2_eq   <= (w_ones == c_all_match);
            end
        end
    end

    // Clear wins over a same-cycle delivery; both counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (w_deliver) begin
            if (!(&r_beat_cnt)) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (!r_s2_eq && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign out_y     = r_s2_y;
    assign out_ones  = r_s2_ones;
    assign out_eq    = r_s2_eq;
    assign err_cnt   = r_err_cnt;
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_logic_gate_pipe                                                          |
// | Randomised scoreboard bench for logic_gate_pipe (16-bit and 4-bit counters).|
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_logic_gate_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready4;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid, out_valid4;
    logic        out_ready = 1'b0;
    logic [7:0]  out_y, out_y4;
    logic [3:0]  out_ones, out_ones4;
    logic        out_eq, out_eq4;
    logic        clr_cnt = 1'b0;
    logic [15:0] err_cnt, beat_cnt;
    logic [3:0]  err_cnt4, beat_cnt4;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_ones(out_ones), .out_eq(out_eq),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt), .beat_cnt(beat_cnt)
    );

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
        .out_ready(out_ready), .out_y(out_y4), .out_ones(out_ones4), .out_eq(out_eq4),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt4), .beat_cnt(beat_cnt4)
    );

    typedef struct {
        logic [7:0] y;
        logic [3:0] ones;
        logic       eq;
        int         cyc;
        int         id;
    } exp_t;

    typedef struct {
        bit         acc;
        bit         dlv;
        bit         have;
        logic       inr;
        logic       ov;
        logic [7:0] y;
        logic [3:0] ones;
        logic       eq;
        logic       ov4;
        logic [7:0] y4;
        logic [3:0] ones4;
        logic       eq4;
        int         cyc;
    } obs_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   next_id = 0;
    int   m_beat16 = 0, m_err16 = 0, m_beat4 = 0, m_err4 = 0;

    // Reference: each op from its truth-table definition; match count bit by bit.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                   input int c, input int id);
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < 8; i++) if (a[i] == b[i]) n++;
        case (op)
            3'd0: e.y = a & b;
            3'd1: e.y = a | b;
            3'd2: e.y = a ^ b;
            3'd3: e.y = ~(a ^ b);
            3'd4: e.y = ~(a & b);
            3'd5: e.y = ~(a | b);
            3'd6: e.y = ~a;
            default: e.y = a;
        endcase
        e.ones = 4'(n);
        e.eq   = (a == b);
        e.cyc  = c;
        e.id   = id;
        return e;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // One clock of stimulus: drive, sample just before the edge, update model at the edge.
    task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input bit ordy, input bit clr, output obs_t o, output exp_t e);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = v ? op : 3'bx;
        out_ready = ordy;
        clr_cnt   = clr;
        #1;
        o.acc = v && in_ready;
        o.dlv = out_valid && ordy;
        o.inr = in_ready;
        o.ov = out_valid; o.y = out_y; o.ones = out_ones; o.eq = out_eq;
        o.ov4 = out_valid4; o.y4 = out_y4; o.ones4 = out_ones4; o.eq4 = out_eq4;
        o.cyc = cyc;
        o.have = 1'b0;
        e = '{y: 8'h00, ones: 4'h0, eq: 1'b0, cyc: 0, id: -1};
        if (o.dlv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o.have = 1'b1;
        end
        if (o.acc) begin
            exp_q.push_back(model(a, b, op, cyc, next_id));
            next_id++;
        end
        @(posedge clk);
        if (clr) begin
            m_beat16 = 0; m_err16 = 0; m_beat4 = 0; m_err4 = 0;
        end else if (o.have) begin
            m_beat16 = sat_inc(m_beat16, 65535);
            m_beat4  = sat_inc(m_beat4, 15);
            if (!e.eq) begin
                m_err16 = sat_inc(m_err16, 65535);
                m_err4  = sat_inc(m_err4, 15);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_y, out_ones, out_eq} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b y=%h ones=%0d eq=%0b, want all 0", out_valid, out_y, out_ones, out_eq);
        end
        n_cmp++;
        if (err_cnt !== 16'h0 || beat_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got err=%0d beat=%0d, want 0/0", err_cnt, beat_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b/%0b, want 1", in_ready, in_ready4);
        end
    endtask

    task automatic test_op_table();
        logic [7:0] tbl [8];
        obs_t o;
        exp_t e;
        int   nd;
        tbl = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(k < 8, 8'hA5, 8'h0F, 3'(k), 1'b1, 1'b0, o, e);
            if (k < 8) begin
                n_cmp++;
                if (o.acc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL optable_accept: op %0d in_ready=%0b, want 1", k, o.inr);
                end
            end
            if (o.dlv && nd < 8) begin
                n_cmp++;
                if (o.y !== tbl[nd] || o.ones !== 4'd4 || o.eq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL optable_value: op %0d got y=%h ones=%0d eq=%0b, want y=%h ones=4 eq=0",
                             nd, o.y, o.ones, o.eq, tbl[nd]);
                end
                n_cmp++;
                if (!o.have || (o.cyc - e.cyc) != 2) begin
                    n_fail++;
                    $display("FAIL optable_latency: op %0d got %0d cycles, want 2", nd, o.cyc - e.cyc);
                end
                nd++;
            end
        end
        n_cmp++;
        if (nd != 8) begin
            n_fail++;
            $display("FAIL optable_count: delivered %0d, want 8", nd);
        end
    endtask

    task automatic test_equality();
        obs_t o;
        exp_t e;
        int   b0, e0, nd;
        b0 = m_beat16;
        e0 = m_err16;
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(k == 0, 8'h3C, 8'h3C, 3'd3, 1'b1, 1'b0, o, e);
            if (o.dlv) begin
                nd++;
                n_cmp++;
                if (o.y !== 8'hFF || o.ones !== 4'd8 || o.eq !== 1'b1) begin
                    n_fail++;
                    $display("FAIL equality_value: got y=%h ones=%0d eq=%0b, want FF/8/1", o.y, o.ones, o.eq);
                end
            end
        end
        n_cmp++;
        if (nd != 1 || beat_cnt !== 16'(b0 + 1) || err_cnt !== 16'(e0)) begin
            n_fail++;
            $display("FAIL equality_counters: got n=%0d beat=%0d err=%0d, want 1/%0d/%0d", nd, beat_cnt, err_cnt, b0 + 1, e0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ba [6], bb [6];
        logic [2:0] bo [6];
        obs_t o, prev;
        exp_t e;
        int   idx, nd, base;
        bit   prev_stall;
        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom); bb[i] = 8'($urandom); bo[i] = 3'($urandom);
        end
        idx = 0; nd = 0; base = next_id; prev_stall = 0;
        prev = '{default: 0};
        for (int i = 0; i < 30 && nd < 6; i++) begin
            cycle(idx < 6, ba[idx % 6], bb[idx % 6], bo[idx % 6], i >= 5, 1'b0, o, e);
            if (o.acc) idx++;
            if (i >= 2 && i <= 4) begin
                n_cmp++;
                if (o.inr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: cycle %0d got in_ready=%0b, want 0", i, o.inr);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (o.ov !== 1'b1 || o.y !== prev.y || o.ones !== prev.ones || o.eq !== prev.eq) begin
                    n_fail++;
                    $display("FAIL bp_stable: got v=%0b y=%h ones=%0d eq=%0b, want 1/%h/%0d/%0b",
                             o.ov, o.y, o.ones, o.eq, prev.y, prev.ones, prev.eq);
                end
            end
            if (o.dlv) begin
                n_cmp++;
                if (!o.have || e.id != base + nd || o.y !== e.y || o.ones !== e.ones || o.eq !== e.eq) begin
                    n_fail++;
                    $display("FAIL bp_data: beat %0d got y=%h ones=%0d eq=%0b, want id %0d y=%h ones=%0d eq=%0b",
                             nd, o.y, o.ones, o.eq, e.id, e.y, e.ones, e.eq);
                end
                nd++;
            end
            prev_stall = o.ov && (i < 5);
            prev = o;
        end
        n_cmp++;
        if (nd != 6 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: delivered %0d left %0d, want 6/0", nd, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        cycle(1'b1, 8'h12, 8'h34, 3'd2, 1'b0, 1'b0, o, e);
        cycle(1'b1, 8'h56, 8'h78, 3'd0, 1'b0, 1'b0, o, e);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_ones !== 4'h0 || out_eq !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got v=%0b y=%h ones=%0d eq=%0b, want all 0", out_valid, out_y, out_ones, out_eq);
        end
        n_cmp++;
        if (err_cnt !== 16'h0 || beat_cnt !== 16'h0 || err_cnt4 !== 4'h0 || beat_cnt4 !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_counters: got err=%0d beat=%0d, want 0/0", err_cnt, beat_cnt);
        end
        exp_q.delete();
        m_beat16 = 0; m_err16 = 0; m_beat4 = 0; m_err4 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, o, e);
            n_cmp++;
            if (o.ov !== 1'b0 || o.inr !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_stale: cycle %0d got out_valid=%0b in_ready=%0b, want 0/1", k, o.ov, o.inr);
            end
        end
    endtask

    task automatic test_saturation();
        obs_t       o;
        exp_t       e;
        logic [7:0] a;
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, o, e);
        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom);
            cycle(k < 20, a, a ^ 8'(($urandom % 255) + 1), 3'($urandom), 1'b1, 1'b0, o, e);
        end
        n_cmp++;
        if (err_cnt4 !== 4'hF || beat_cnt4 !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_cnt4: got err=%h beat=%h, want F/F", err_cnt4, beat_cnt4);
        end
        n_cmp++;
        if (err_cnt !== 16'(m_err16) || beat_cnt !== 16'(m_beat16) || m_beat16 != 20) begin
            n_fail++;
            $display("FAIL sat_cnt16: got err=%0d beat=%0d, want 20/20", err_cnt, beat_cnt);
        end
        cycle(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b1, 1'b0, o, e);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, o, e);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, o, e);
        n_cmp++;
        if (o.dlv !== 1'b1 || err_cnt4 !== 4'h0 || beat_cnt4 !== 4'h0 || err_cnt !== 16'h0 || beat_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL sat_clr_priority: dlv=%0b got err4=%h beat4=%h err=%0d beat=%0d, want 1 and all 0",
                     o.dlv, err_cnt4, beat_cnt4, err_cnt, beat_cnt);
        end
    endtask

    task automatic test_random();
        obs_t       o;
        exp_t       e;
        logic [7:0] a, b;
        logic [2:0] op;
        bit         pend;
        int         nacc;
        pend = 0; nacc = 0; a = '0; b = '0; op = '0;
        for (int i = 0; i < 60000 && nacc < 10000; i++) begin
            if (!pend && ($urandom % 10) < 7) begin
                pend = 1;
                a  = 8'($urandom);
                b  = (($urandom % 4) == 0) ? a : 8'($urandom);
                op = 3'($urandom);
            end
            cycle(pend, a, b, op, ($urandom % 10) < 7, 1'b0, o, e);
            if (o.acc) begin
                pend = 0;
                nacc++;
            end
            if (o.dlv) begin
                n_cmp++;
                if (!o.have || {o.y, o.ones, o.eq} !== {e.y, e.ones, e.eq}
                    || {o.ov4, o.y4, o.ones4, o.eq4} !== {1'b1, e.y, e.ones, e.eq}) begin
                    n_fail++;
                    $display("FAIL rand_beat: id %0d got y=%h ones=%0d eq=%0b (w4 y=%h), want y=%h ones=%0d eq=%0b",
                             e.id, o.y, o.ones, o.eq, o.y4, e.y, e.ones, e.eq);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, o, e);
            if (o.dlv) begin
                n_cmp++;
                if (!o.have || {o.y, o.ones, o.eq} !== {e.y, e.ones, e.eq}) begin
                    n_fail++;
                    $display("FAIL rand_drain: got y=%h ones=%0d eq=%0b, want y=%h ones=%0d eq=%0b",
                             o.y, o.ones, o.eq, e.y, e.ones, e.eq);
                end
            end
        end
        n_cmp++;
        if (nacc != 10000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_complete: accepted %0d pending %0d, want 10000/0", nacc, exp_q.size());
        end
        n_cmp++;
        if (err_cnt !== 16'(m_err16) || beat_cnt !== 16'(m_beat16)) begin
            n_fail++;
            $display("FAIL rand_cnt16: got err=%0d beat=%0d, want %0d/%0d", err_cnt, beat_cnt, m_err16, m_beat16);
        end
        n_cmp++;
        if (err_cnt4 !== 4'(m_err4) || beat_cnt4 !== 4'(m_beat4)) begin
            n_fail++;
            $display("FAIL rand_cnt4: got err=%0d beat=%0d, want %0d/%0d", err_cnt4, beat_cnt4, m_err4, m_beat4);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_op_table();
        test_equality();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
